uart_mem_bridge: RTL and testbench
==================================

# uart_mem_bridge

Command-driven bridge between a byte-wide UART receiver/transmitter and the secondary write/read port of the 128×32 data RAM. It decodes a small byte protocol from the UART receiver, assembles little-endian 32-bit words, and writes them through the RAM's UART port. It also reads RAM words and serialises them back as four bytes to the UART transmitter. This lets a host load programs/data and inspect memory while the MIPS core runs.

## Interface
- BIT_WIDTH, 32, RAM word width; fixed at 32 (four bytes per word)
- ADDR_W, 7, RAM address width (128 words)
- clk  input  1  single system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe; rx_data valid; no backpressure available
- tx_data  output  8  byte to transmitter
- tx_valid  output  1  tx_data valid; held until accepted
- tx_ready  input  1  transmitter accepts byte when tx_valid&&tx_ready
- ADDR_UART  output  ADDR_W  RAM UART-port address
- WRITE_UART  output  BIT_WIDTH  RAM UART-port write data
- W_UART  output  1  RAM UART-port write enable, one cycle per word
- READ_UART  input  BIT_WIDTH  RAM UART-port read data (combinational from ADDR_UART)
- busy  output  1  high in any state other than IDLE

## Operation
- Protocol: write = 0x57, addr, d0, d1, d2, d3; read = 0x52, addr. Address uses byte bits [6:0]; bit 7 ignored.
- Word assembly is little-endian: d0 goes to [7:0] and d3 to [31:24].
- States: IDLE, ADDR, DATA, WRITE, READ, SEND, and RESP (RESP exists only with the macro).
- IDLE: on rx_valid, 0x57/0x52 latches the command and moves to ADDR. Any other byte: see Configuration.
- ADDR: on rx_valid, latch ADDR_UART. Write goes to DATA with the byte counter at 0. Read goes to READ.
- DATA: each rx_valid shifts a byte into WRITE_UART and increments a 2-bit counter. After the 4th byte, go to WRITE.
- WRITE: W_UART=1 for exactly this cycle. Next state is RESP if the macro is defined, else IDLE.
- READ: register READ_UART into a 32-bit shift register. Go to SEND with the counter at 0.
- SEND: tx_data is the low byte. On each handshake, shift right 8 and increment. After the 4th handshake, go to IDLE.
- rx_valid in WRITE, READ, SEND or RESP is dropped. No error is flagged.
- Reset values: state IDLE, ADDR_UART 0, WRITE_UART 0, W_UART 0, tx_data 0, tx_valid 0, busy 0, counter 0.
- Reset mid-transaction aborts it. No W_UART pulse is issued for a partially received word.

## Timing
- Write: last data byte rx_valid at cycle N gives W_UART=1 in N+1. The RAM updates at the end of N+1. IDLE (or RESP) in N+2.
- Read: address byte at cycle N gives READ in N+1 (ADDR_UART stable, READ_UART sampled). tx_valid=1 from N+2.
- tx_valid stays high across all four bytes. After a handshake the next byte is presented the following cycle. Data is stable while tx_valid && !tx_ready.
- Minimum spacing between rx_valid strobes is 1 cycle. Back-to-back strobes in ADDR and DATA are accepted every cycle.
- Response ordering: a byte is never emitted until the previous one has handshaken.

## Configuration
- UART_MEM_BRIDGE_ACK_EN defined:
  - After WRITE, enter RESP and transmit 0x06 (ACK), then return to IDLE.
  - An unknown command byte in IDLE enters RESP and transmits 0x15 (NAK).
- Undefined:
  - RESP state is absent. WRITE returns directly to IDLE.
  - Unknown command bytes are silently discarded and the block stays in IDLE.

## Structure
- Package uart_mem_bridge_pkg holds:
  - state enum
  - CMD_WRITE=8'h57, CMD_READ=8'h52, ACK_BYTE=8'h06, NAK_BYTE=8'h15
  - ADDR_W
- Sub-module word_serializer: 32-bit load, 4-byte valid/ready output, done pulse; used by SEND.
- Top level: protocol FSM, address/data capture registers.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0, busy=0, W_UART never asserted.
- Send 57,05,78,56,34,12: one W_UART pulse with ADDR_UART=5, WRITE_UART=0x12345678. RAM word 5 reads 0x12345678.
- Preload word 0x7F=0xDEADBEEF, send 52,FF: tx emits EF,BE,AD,DE. With tx_ready stalled 3 cycles per byte, each byte holds stable.
- Assert rst after 57,03,AA: returns to IDLE, no W_UART. A following full write to address 3 succeeds.
- Send 41: with ACK_EN, tx emits 15. Without it, no tx activity and busy stays 0. With ACK_EN, a valid write is followed by tx 06.
- Send 52,01 and inject extra rx_valid bytes during SEND: they are ignored. The next command after SEND completes decodes correctly.

Source files
------------

// File: rtl/uart_mem_bridge_pkg.sv
// uart_mem_bridge shared types and protocol constants.
// UART_MEM_BRIDGE_ACK_EN adds the RESP state for ACK/NAK replies.
package uart_mem_bridge_pkg;

    localparam int BIT_WIDTH = 32;
    localparam int ADDR_W    = 7;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_READ,
        ST_SEND
`ifdef UART_MEM_BRIDGE_ACK_EN
        ,
        ST_RESP
`endif
    } state_e;

endpackage

// File: rtl/uart_mem_bridge_if.sv
// Bundle of UART byte streams and RAM UART-port signals.
// master = bridge side, slave = UART/RAM side.
interface uart_mem_bridge_if;
    import uart_mem_bridge_pkg::*;

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [ADDR_W-1:0]    ADDR_UART;
    logic [BIT_WIDTH-1:0] WRITE_UART;
    logic                 W_UART;
    logic [BIT_WIDTH-1:0] READ_UART;
    logic                 busy;

    modport master (
        input  rx_data, rx_valid, tx_ready, READ_UART,
        output tx_data, tx_valid, ADDR_UART, WRITE_UART,
        output W_UART, busy
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, READ_UART,
        input  tx_data, tx_valid, ADDR_UART, WRITE_UART,
        input  W_UART, busy
    );

endinterface

// File: rtl/uart_mem_bridge_serializer.sv
// word_serializer: loads a 32-bit word and emits it as four
// little-endian bytes over valid/ready, pulsing done on the last.
module word_serializer
    import uart_mem_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] word,
    output logic [7:0]           byte_data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 done
);

    logic [BIT_WIDTH-1:0] sreg;
    logic [1:0]           cnt;
    logic                 vld;

    // Shift register advances one byte per accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            sreg <= word;
            cnt  <= '0;
            vld  <= 1'b1;
        end else if (vld && ready) begin
            sreg <= sreg >> 8;
            cnt  <= cnt + 2'd1;
            if (cnt == 2'd3) begin
                vld <= 1'b0;
            end
        end
    end

    assign byte_data = sreg[7:0];
    assign valid     = vld;
    assign done      = vld && ready && (cnt == 2'd3);

endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: byte-protocol bridge from UART to the RAM UART port.
// Define UART_MEM_BRIDGE_ACK_EN to reply ACK after writes, NAK on bad commands.
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    uart_mem_bridge_if.master bus
);

    state_e               state_q;
    state_e               state_d;
    logic [ADDR_W-1:0]    addr_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic [1:0]           cnt_q;
    logic                 wr_cmd_q;
    logic                 cmd_known;

    logic                 ser_load;
    logic [7:0]           ser_byte;
    logic                 ser_valid;
    logic                 ser_done;

`ifdef UART_MEM_BRIDGE_ACK_EN
    logic                 nak_q;
`endif

    assign cmd_known = (bus.rx_data == CMD_WRITE) ||
                       (bus.rx_data == CMD_READ);

    // Protocol state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command, address and little-endian data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            wr_cmd_q <= 1'b0;
`ifdef UART_MEM_BRIDGE_ACK_EN
            nak_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        wr_cmd_q <= (bus.rx_data == CMD_WRITE);
`ifdef UART_MEM_BRIDGE_ACK_EN
                        nak_q    <= !cmd_known;
`endif
                    end
                end
                ST_ADDR: begin
                    if (bus.rx_valid) begin
                        addr_q <= bus.rx_data[ADDR_W-1:0];
                        cnt_q  <= '0;
                    end
                end
                ST_DATA: begin
                    if (bus.rx_valid) begin
                        wdata_q <= {bus.rx_data, wdata_q[BIT_WIDTH-1:8]};
                        cnt_q   <= cnt_q + 2'd1;
                    end
                end
`ifdef UART_MEM_BRIDGE_ACK_EN
                ST_WRITE: begin
                    nak_q <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // Next-state decode; bytes outside IDLE/ADDR/DATA are dropped.
    always_comb begin
        state_d  = state_q;
        ser_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (cmd_known) begin
                        state_d = ST_ADDR;
                    end else begin
`ifdef UART_MEM_BRIDGE_ACK_EN
                        state_d = ST_RESP;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    state_d = wr_cmd_q ? ST_DATA : ST_READ;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid && (cnt_q == 2'd3)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
`ifdef UART_MEM_BRIDGE_ACK_EN
                state_d = ST_RESP;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_READ: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef UART_MEM_BRIDGE_ACK_EN
            ST_RESP: begin
                if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    word_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (bus.READ_UART),
        .byte_data (ser_byte),
        .valid     (ser_valid),
        .ready     (bus.tx_ready),
        .done      (ser_done)
    );

    assign bus.ADDR_UART  = addr_q;
    assign bus.WRITE_UART = wdata_q;
    assign bus.W_UART     = (state_q == ST_WRITE);
    assign bus.busy       = (state_q != ST_IDLE);

`ifdef UART_MEM_BRIDGE_ACK_EN
    assign bus.tx_valid = ser_valid || (state_q == ST_RESP);
    assign bus.tx_data  = (state_q == ST_RESP) ?
                          (nak_q ? NAK_BYTE : ACK_BYTE) : ser_byte;
`else
    assign bus.tx_valid = ser_valid;
    assign bus.tx_data  = ser_byte;
`endif

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge with a 128x32 RAM model.
// Build with UART_MEM_BRIDGE_ACK_EN to cover ACK/NAK replies.
module tb_uart_mem_bridge;
    import uart_mem_bridge_pkg::*;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_mem_bridge_if bus ();

    uart_mem_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [128];
    logic        pre_we   = 1'b0;
    logic [6:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    assign bus.READ_UART = mem[bus.ADDR_UART];

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (bus.W_UART) mem[bus.ADDR_UART] <= bus.WRITE_UART;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int stall = 0;

    logic [7:0] exp_tx [$];
    wr_t        exp_wr [$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // tx_ready pattern: low for 'stall' cycles, then high one cycle.
    initial begin
        int w;
        w = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall == 0) begin
                bus.tx_ready = 1'b1;
            end else if (w >= stall) begin
                bus.tx_ready = 1'b1;
                w = 0;
            end else begin
                bus.tx_ready = 1'b0;
                w++;
            end
        end
    end

    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = '0;
    wr_t        e;

    // Output monitor: pops the scoreboard on writes and tx handshakes.
    always @(negedge clk) begin
        if (bus.W_UART) begin
            if (exp_wr.size() == 0) begin
                check("w_unexp", 1, 0);
            end else begin
                e = exp_wr.pop_front();
                check("w_addr", 32'(bus.ADDR_UART), 32'(e.a));
                check("w_data", bus.WRITE_UART, e.d);
            end
        end
        if (bus.tx_valid && bus.tx_ready) begin
            if (exp_tx.size() == 0)
                check("tx_unexp", 1, 0);
            else
                check("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
        end
        if (prev_v && !prev_r && !rst)
            check("tx_hold", {23'd0, bus.tx_valid, bus.tx_data},
                  {23'd0, 1'b1, prev_d});
        prev_v <= bus.tx_valid;
        prev_r <= bus.tx_ready;
        prev_d <= bus.tx_data;
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.busy && exp_tx.size() == 0) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("idle_timeout", 32'(ok), 1);
    endtask

    task automatic write_word(input logic [7:0] ab, input logic [31:0] d);
        wr_t w;
        w.a = ab[6:0];
        w.d = d;
        exp_wr.push_back(w);
`ifdef UART_MEM_BRIDGE_ACK_EN
        exp_tx.push_back(ACK_BYTE);
`endif
        send_byte(CMD_WRITE);
        send_byte(ab);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        check("w_pulse", 32'(bus.W_UART), 1);
        tick();
        check("w_once", 32'(bus.W_UART), 0);
`ifndef UART_MEM_BRIDGE_ACK_EN
        check("w_to_idle", 32'(bus.busy), 0);
`endif
        wait_idle();
    endtask

    task automatic read_word(input logic [7:0] ab, input logic [31:0] d);
        for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
        send_byte(CMD_READ);
        send_byte(ab);
        check("rd_addr", 32'(bus.ADDR_UART), 32'(ab[6:0]));
        check("rd_n1_valid", 32'(bus.tx_valid), 0);
        tick();
        check("rd_n2_valid", 32'(bus.tx_valid), 1);
        wait_idle();
    endtask

    initial begin
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and quiet idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_flags",
                  {29'd0, bus.busy, bus.W_UART, bus.tx_valid}, 0);
        end
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_addr", 32'(bus.ADDR_UART), 0);
        check("rst_wdata", bus.WRITE_UART, 0);
        tick();

        // Basic write then read-back.
        write_word(8'h05, 32'h1234_5678);
        check("ram_5", mem[5], 32'h1234_5678);
        read_word(8'h05, 32'h1234_5678);

        // Read top word with stalled transmitter; bit 7 of addr ignored.
        preload(7'h7F, 32'hDEAD_BEEF);
        stall = 3;
        read_word(8'hFF, 32'hDEAD_BEEF);
        stall = 0;

        // Reset in the middle of a write.
        send_byte(CMD_WRITE);
        send_byte(8'h03);
        send_byte(8'hAA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_wdata", bus.WRITE_UART, 0);
        check("abort_addr", 32'(bus.ADDR_UART), 0);
        repeat (4) tick();
        write_word(8'h03, 32'h4433_2211);
        check("ram_3", mem[3], 32'h4433_2211);
        read_word(8'h03, 32'h4433_2211);

        // Unknown command byte.
`ifdef UART_MEM_BRIDGE_ACK_EN
        exp_tx.push_back(NAK_BYTE);
        send_byte(8'h41);
        wait_idle();
`else
        send_byte(8'h41);
        for (int i = 0; i < 5; i++) begin
            check("unk_quiet", {30'd0, bus.busy, bus.tx_valid}, 0);
            tick();
        end
`endif

        // Stray bytes while SEND is in progress are ignored.
        preload(7'h01, 32'hCAFE_0102);
        stall = 2;
        for (int i = 0; i < 4; i++) exp_tx.push_back(8'(32'hCAFE_0102 >> (8*i)));
        send_byte(CMD_READ);
        send_byte(8'h01);
        tick();
        send_byte(CMD_WRITE);
        tick();
        send_byte(CMD_WRITE);
        send_byte(CMD_READ);
        check("send_busy", 32'(bus.busy), 1);
        wait_idle();
        stall = 0;
        write_word(8'h09, 32'h0BAD_F00D);
        read_word(8'h89, 32'h0BAD_F00D);

        // Back-to-back write with all-ones data.
        write_word(8'h7F, 32'hFFFF_FFFF);
        read_word(8'h7F, 32'hFFFF_FFFF);

        repeat (5) tick();
        check("tx_left", exp_tx.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
